// File: rtl/ajc_alu_op_sequencer_if.sv
// ajc_alu_op_sequencer_if: command, load, debug-read and ALU-drive bundle for the op sequencer
interface ajc_alu_op_sequencer_if;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [3:0] Cmd_Func;
  logic [1:0] Cmd_SrcX;
  logic [1:0] Cmd_SrcY;
  logic [1:0] Cmd_Dst;
  logic [1:0] Cmd_K;
  logic       Cmd_Cin;
  logic       Cmd_WrEn;
  logic       Ld_En;
  logic [1:0] Ld_Addr;
  logic [7:0] Ld_Data;
  logic [1:0] Rd_Addr;
  logic [7:0] Rd_Data;
  logic [3:0] Func_Sel;
  logic [7:0] Operand_X;
  logic [7:0] Operand_Y;
  logic [1:0] Const_K;
  logic       Cin;
  logic [7:0] ALU_Result;
  logic [3:0] ALU_CNVZ;
  logic [3:0] CNVZ;
  logic       Done;
  modport slave (
    input  Cmd_Valid, Cmd_Func, Cmd_SrcX, Cmd_SrcY, Cmd_Dst, Cmd_K, Cmd_Cin, Cmd_WrEn,
    input  Ld_En, Ld_Addr, Ld_Data, Rd_Addr, ALU_Result, ALU_CNVZ,
    output Cmd_Ready, Rd_Data, Func_Sel, Operand_X, Operand_Y, Const_K, Cin, CNVZ, Done
  );
  modport master (
    output Cmd_Valid, Cmd_Func, Cmd_SrcX, Cmd_SrcY, Cmd_Dst, Cmd_K, Cmd_Cin, Cmd_WrEn,
    output Ld_En, Ld_Addr, Ld_Data, Rd_Addr, ALU_Result, ALU_CNVZ,
    input  Cmd_Ready, Rd_Data, Func_Sel, Operand_X, Operand_Y, Const_K, Cin, CNVZ, Done
  );
endinterface

// File: rtl/ajc_alu_op_sequencer.sv
// ajc_alu_op_sequencer: IDLE/READ/EXEC/WB ALU command sequencer with 4x8 register file; define AJC_SEQ_CARRY_CHAIN_EN to feed CNVZ[3] as carry-in
module ajc_alu_op_sequencer #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic Clock,
  input logic Reset,
  ajc_alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t state, state_nx;
  logic accept, cin_sel, c_cin, c_wr;
  logic [3:0] c_func, flags_q;
  logic [1:0] c_sx, c_sy, c_dst, c_k;
  logic [7:0] res_q;
  logic [7:0] regs [4];

  // state register
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;

  // next state plus handshake and retire outputs
  always_comb begin
    bus.Cmd_Ready = state == IDLE;
    bus.Done = state == WB;
    accept = bus.Cmd_Ready && bus.Cmd_Valid;
    state_nx = state == IDLE ? (accept ? READ : IDLE) : state == READ ? EXEC : state == EXEC ? WB : IDLE;
  end

`ifdef AJC_SEQ_CARRY_CHAIN_EN
  assign cin_sel = bus.CNVZ[3];
`else
  assign cin_sel = c_cin;
`endif

  // command latch, ALU drive on the READ edge, result capture at the end of EXEC
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      {c_func, c_sx, c_sy, c_dst, c_k, c_cin, c_wr} <= '0;
      bus.Func_Sel <= '0;
      bus.Operand_X <= '0;
      bus.Operand_Y <= '0;
      bus.Const_K <= '0;
      bus.Cin <= 1'b0;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      if (accept)
        {c_func, c_sx, c_sy, c_dst, c_k, c_cin, c_wr} <=
          {bus.Cmd_Func, bus.Cmd_SrcX, bus.Cmd_SrcY, bus.Cmd_Dst, bus.Cmd_K, bus.Cmd_Cin, bus.Cmd_WrEn};
      if (state == READ) begin
        bus.Func_Sel <= c_func;
        bus.Operand_X <= regs[c_sx];
        bus.Operand_Y <= regs[c_sy];
        bus.Const_K <= c_k;
        bus.Cin <= cin_sel;
      end
      if (state == EXEC) begin
        res_q <= bus.ALU_Result;
        flags_q <= bus.ALU_CNVZ;
      end
    end

  // register file and status: external loads only while idle, write-back and flags in WB
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      regs <= '{default: '0};
      bus.CNVZ <= RESET_FLAGS;
    end else begin
      if (state == IDLE && bus.Ld_En) regs[bus.Ld_Addr] <= bus.Ld_Data;
      if (state == WB) begin
        if (c_wr) regs[c_dst] <= res_q;
        bus.CNVZ <= flags_q;
      end
    end

  assign bus.Rd_Data = regs[bus.Rd_Addr];
endmodule

// File: tb/tb_ajc_alu_op_sequencer.sv
// tb_ajc_alu_op_sequencer: randomized scoreboard bench for the ALU op sequencer with an X+Y+Cin ALU stub
module tb_ajc_alu_op_sequencer;
  localparam logic [3:0] RF = 4'b0110;

  typedef struct {
    int         acc;
    int         gap;
    logic       b2b;
    logic [3:0] func;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] k;
    logic       cin;
    logic [3:0] cnvz;
    logic [3:0][7:0] regs;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int tmo = 0;
  int rst_req = 0;
  int last_acc = 0;
  logic held = 1'b0;
  logic stim_done = 1'b0;
  logic [7:0] m_reg [4];
  logic [3:0] m_cnvz;
  exp_t q[$];
  logic [8:0] alu_sum;

  ajc_alu_op_sequencer_if bus();

  ajc_alu_op_sequencer #(.RESET_FLAGS(RF)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  assign alu_sum = {1'b0, bus.Operand_X} + {1'b0, bus.Operand_Y} + {8'd0, bus.Cin};
  assign bus.ALU_Result = alu_sum[7:0];
  assign bus.ALU_CNVZ = {alu_sum[8], alu_sum[7],
                         (bus.Operand_X[7] == bus.Operand_Y[7]) && (alu_sum[7] != bus.Operand_X[7]),
                         alu_sum[7:0] == 8'd0};

  function automatic logic [11:0] ref_alu(input logic [7:0] x, input logic [7:0] y, input logic c);
    int u, sx, sy, sv;
    logic [7:0] r;
    u = int'(x) + int'(y) + int'(c);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sv = sx + sy + int'(c);
    r = u[7:0];
    return {u > 255, r[7], sv > 127 || sv < -128, r == 8'd0, r};
  endfunction

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, req, cyc);
    end
  endfunction

  task automatic ld(input logic [1:0] a, input logic [7:0] d);
    bus.Ld_En = 1'b1;
    bus.Ld_Addr = a;
    bus.Ld_Data = d;
    if (bus.Cmd_Ready) m_reg[a] = d;
    @(negedge Clock);
    bus.Ld_En = 1'b0;
  endtask

  task automatic issue(input logic [3:0] f, input logic [1:0] sx, input logic [1:0] sy, input logic [1:0] d,
                       input logic [1:0] k, input logic ci, input logic wr, input logic hold,
                       input logic le, input logic [1:0] la, input logic [7:0] ldat);
    exp_t e;
    int n;
    logic [11:0] o;
    n = 0;
    bus.Cmd_Func = f;
    bus.Cmd_SrcX = sx;
    bus.Cmd_SrcY = sy;
    bus.Cmd_Dst = d;
    bus.Cmd_K = k;
    bus.Cmd_Cin = ci;
    bus.Cmd_WrEn = wr;
    bus.Cmd_Valid = 1'b1;
    bus.Ld_En = le;
    bus.Ld_Addr = la;
    bus.Ld_Data = ldat;
    while (!bus.Cmd_Ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!bus.Cmd_Ready) begin
      tmo++;
      bus.Cmd_Valid = 1'b0;
      bus.Ld_En = 1'b0;
      held = 1'b0;
      return;
    end
    if (le) m_reg[la] = ldat;
    e.acc = cyc + 1;
    e.b2b = held;
    e.gap = e.acc - last_acc;
    e.func = f;
    e.k = k;
    e.x = m_reg[sx];
    e.y = m_reg[sy];
`ifdef AJC_SEQ_CARRY_CHAIN_EN
    e.cin = m_cnvz[3];
`else
    e.cin = ci;
`endif
    o = ref_alu(e.x, e.y, e.cin);
    e.cnvz = o[11:8];
    if (wr) m_reg[d] = o[7:0];
    m_cnvz = e.cnvz;
    for (int i = 0; i < 4; i++) e.regs[i] = m_reg[i];
    q.push_back(e);
    last_acc = e.acc;
    held = hold;
    @(negedge Clock);
    if (!hold) bus.Cmd_Valid = 1'b0;
    bus.Ld_En = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
    m_cnvz = RF;
    held = 1'b0;
    bus.Cmd_Valid = 1'b0;
    bus.Ld_En = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    rst_req++;
    repeat (2) @(negedge Clock);
  endtask

  initial begin
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Func = '0;
    bus.Cmd_SrcX = '0;
    bus.Cmd_SrcY = '0;
    bus.Cmd_Dst = '0;
    bus.Cmd_K = '0;
    bus.Cmd_Cin = 1'b0;
    bus.Cmd_WrEn = 1'b0;
    bus.Ld_En = 1'b0;
    bus.Ld_Addr = '0;
    bus.Ld_Data = '0;
    repeat (2) @(negedge Clock);
    do_reset();
    ld(2'd1, 8'h7F);
    ld(2'd2, 8'h01);
    issue(4'h0, 2'd1, 2'd2, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) @(negedge Clock);
    ld(2'd0, 8'hFF);
    ld(2'd1, 8'h01);
    issue(4'h1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) @(negedge Clock);
    ld(2'd2, 8'h00);
    ld(2'd3, 8'h00);
    issue(4'h2, 2'd2, 2'd3, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) @(negedge Clock);
    ld(2'd1, 8'h40);
    issue(4'h3, 2'd1, 2'd1, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) @(negedge Clock);
    issue(4'h4, 2'd2, 2'd3, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'h5A);
    issue(4'h5, 2'd0, 2'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    issue(4'h6, 2'd1, 2'd0, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    issue(4'h7, 2'd3, 2'd1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge Clock);
    ld(2'd0, 8'hAA);
    for (int it = 0; it < 30; it++) begin
      logic hold;
      hold = (it < 29) && ($urandom_range(3) == 0);
      if (!held) repeat ($urandom_range(2)) ld(2'($urandom_range(3)), 8'($urandom));
      issue(4'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
            2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)), hold,
            $urandom_range(3) == 0, 2'($urandom_range(3)), 8'($urandom));
      if (!hold && $urandom_range(1) == 1) begin
        @(negedge Clock);
        ld(2'($urandom_range(3)), 8'($urandom));
      end
    end
    repeat (3) @(negedge Clock);
    ld(2'd1, 8'h33);
    issue(4'h9, 2'd1, 2'd1, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge Clock);
    do_reset();
    ld(2'd0, 8'h11);
    ld(2'd3, 8'h22);
    issue(4'hA, 2'd0, 2'd3, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    stim_done = 1'b1;
  end

  initial begin
    exp_t e;
    int rst_seen;
    int idle;
    rst_seen = 0;
    idle = 0;
    bus.Rd_Addr = 2'd0;
    while (1) begin
      @(negedge Clock);
      if (stim_done && q.size() == 0) break;
      if (stim_done) idle++;
      if (idle > 100) break;
      chk("done_ready_excl", 32'(bus.Done && bus.Cmd_Ready), 32'd0);
      if (rst_req != rst_seen) begin
        rst_seen = rst_req;
        chk("rst_ready", 32'(bus.Cmd_Ready), 32'd1);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_cnvz", 32'(bus.CNVZ), 32'(RF));
        chk("rst_func_sel", 32'(bus.Func_Sel), 32'd0);
        chk("rst_operand_x", 32'(bus.Operand_X), 32'd0);
        chk("rst_operand_y", 32'(bus.Operand_Y), 32'd0);
        chk("rst_const_k", 32'(bus.Const_K), 32'd0);
        chk("rst_cin", 32'(bus.Cin), 32'd0);
        for (int i = 0; i < 4; i++) begin
          bus.Rd_Addr = 2'(i);
          #1;
          chk($sformatf("rst_reg%0d", i), 32'(bus.Rd_Data), 32'd0);
        end
      end else if (bus.Done) begin
        chk("done_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("done_latency", 32'(cyc), 32'(e.acc + 2));
          if (e.b2b) chk("accept_spacing", 32'(e.gap), 32'd4);
          chk("func_sel", 32'(bus.Func_Sel), 32'(e.func));
          chk("operand_x", 32'(bus.Operand_X), 32'(e.x));
          chk("operand_y", 32'(bus.Operand_Y), 32'(e.y));
          chk("const_k", 32'(bus.Const_K), 32'(e.k));
          chk("cin", 32'(bus.Cin), 32'(e.cin));
          @(posedge Clock);
          #1;
          chk("done_pulse", 32'(bus.Done), 32'd0);
          chk("cnvz", 32'(bus.CNVZ), 32'(e.cnvz));
          for (int i = 0; i < 4; i++) begin
            bus.Rd_Addr = 2'(i);
            #1;
            chk($sformatf("reg%0d", i), 32'(bus.Rd_Data), 32'(e.regs[i]));
          end
        end
      end
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("stim_timeouts", 32'(tmo), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
